inst_fetch: RTL and testbench

Instruction-fetch initiator that drives the combinational instruction ROM's addr/data/accessable interface from a program counter. Buffers fetched words in a small FIFO and presents them to the decode stage over a valid/ready handshake. Accepts PC redirects from branch, jump and exception logic. Converts ROM non-accessable responses into tagged fault entries.

---
 rtl/inst_fetch.sv | 122 ++++++++++++
 tb/tb_inst_fetch.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: drives the combinational ROM from the PC, buffers
// fetched words (or fault markers) in a small FIFO and hands them to decode.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        rom_accessable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_fault,
    output logic        fetch_halted
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } fetch_entry_t;

    logic [31:0]      pc_q, pc_d;
    logic             halted_q, halted_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_d;
    fetch_entry_t     out_entry_q, out_entry_d;
    fetch_entry_t     new_entry;
    fetch_entry_t     mem_q [DEPTH];
    logic             full;
    logic             pop;
    logic             push;

    assign rom_addr     = pc_q;
    assign out_inst     = out_entry_q.inst;
    assign out_pc       = out_entry_q.pc;
    assign out_fault    = out_entry_q.fault;
    assign fetch_halted = halted_q;

    // Next-state: redirect flushes everything; otherwise fetch whenever a slot frees up.
    always_comb begin
        pc_d        = pc_q;
        halted_d    = halted_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid;
        out_entry_d = out_entry_q;

        full            = (count_q == CNT_W'(DEPTH));
        pop             = out_valid & out_ready;
        push            = !redirect_valid & !halted_q & (!full | pop);
        new_entry.pc    = pc_q;
        new_entry.inst  = rom_accessable ? rom_data : 32'h0;
        new_entry.fault = !rom_accessable;

        if (redirect_valid) begin
            pc_d        = redirect_pc;
            halted_d    = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (new_entry.fault) begin
                    halted_d = 1'b1;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
            out_valid_d = (count_d != '0);
            // Head comes from the bypassed new entry when the buffer would otherwise be empty.
            if (count_d != '0) begin
                out_entry_d = (count_q == CNT_W'(pop)) ? new_entry : mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= RESET_PC;
            halted_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid   <= 1'b0;
            out_entry_q <= '0;
        end else begin
            pc_q        <= pc_d;
            halted_q    <= halted_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid   <= out_valid_d;
            out_entry_q <= out_entry_d;
        end
    end

    // Storage array needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized traffic checked
// against a queue-based model of the fetch buffer.
module tb_inst_fetch;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_accessable;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;
    logic        fetch_halted;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc = 32'h0;
    logic        m_halt = 1'b0;

    inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
        .rom_accessable(rom_accessable), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_fault(out_fault),
        .fetch_halted(fetch_halted)
    );

    always #5 clk = ~clk;

    function automatic logic rom_acc(input logic [31:0] a);
        return (a[1:0] == 2'b00) &&
               ((a < 32'h0000_000C) || (a >= 32'h0040_0000 && a < 32'h0040_0100) ||
                (a >= 32'hFFFF_FFF0));
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h3c11_0040;
            32'h0000_0004: return 32'h0810_0056;
            32'h0000_0008: return 32'h0220_0008;
            default:       return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    // ROM returns garbage on a miss so the bench sees whether the DUT zeroes it.
    always_comb begin
        rom_accessable = rom_acc(rom_addr);
        rom_data       = rom_accessable ? rom_word(rom_addr) : 32'hDEAD_BEEF;
    end

    task automatic apply_reset(input logic ready);
        out_ready      = ready;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mq.delete();
        m_pc   = 32'h0;
        m_halt = 1'b0;
    endtask

    // One clock of stimulus with the reference model advanced alongside.
    task automatic step(input logic ready, input logic redir, input logic [31:0] rpc);
        logic pop;
        ent_t e;
        out_ready      = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        pop = (mq.size() != 0) && ready;
        if (redir) begin
            mq.delete();
            m_pc   = rpc;
            m_halt = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (!m_halt && mq.size() < int'(DEPTH)) begin
                e.pc = m_pc;
                if (rom_acc(m_pc)) begin
                    e.inst  = rom_word(m_pc);
                    e.fault = 1'b0;
                end else begin
                    e.inst  = 32'h0;
                    e.fault = 1'b1;
                end
                mq.push_back(e);
                if (e.fault) m_halt = 1'b1;
                else m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_vec++; if (out_inst !== 32'h0) begin n_err++; $display("FAIL reset_inst got %h want 0", out_inst); end
        n_vec++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", out_pc); end
        n_vec++; if (out_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got %b want 0", out_fault); end
        n_vec++; if (fetch_halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", fetch_halted); end
        n_vec++; if (rom_addr !== 32'h0) begin n_err++; $display("FAIL reset_rom_addr got %h want 0", rom_addr); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_boot_sequence();
        ent_t got[$];
        ent_t e;
        logic [31:0] exp_pc[4];
        logic [31:0] exp_inst[4];
        logic        exp_fault[4];
        exp_pc[0] = 32'h0; exp_inst[0] = 32'h3c11_0040; exp_fault[0] = 1'b0;
        exp_pc[1] = 32'h4; exp_inst[1] = 32'h0810_0056; exp_fault[1] = 1'b0;
        exp_pc[2] = 32'h8; exp_inst[2] = 32'h0220_0008; exp_fault[2] = 1'b0;
        exp_pc[3] = 32'hC; exp_inst[3] = 32'h0;         exp_fault[3] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                e.pc = out_pc; e.inst = out_inst; e.fault = out_fault;
                got.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        n_vec++; if (got.size() != 4) begin n_err++; $display("FAIL boot_count got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_vec++; if (got[i].pc !== exp_pc[i]) begin n_err++; $display("FAIL boot_pc[%0d] got %h want %h", i, got[i].pc, exp_pc[i]); end
            n_vec++; if (got[i].inst !== exp_inst[i]) begin n_err++; $display("FAIL boot_inst[%0d] got %h want %h", i, got[i].inst, exp_inst[i]); end
            n_vec++; if (got[i].fault !== exp_fault[i]) begin n_err++; $display("FAIL boot_fault[%0d] got %b want %b", i, got[i].fault, exp_fault[i]); end
        end
        n_vec++; if (fetch_halted !== 1'b1) begin n_err++; $display("FAIL boot_halted got %b want 1", fetch_halted); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL boot_drained got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] pcs[$];
        logic        flt[$];
        apply_reset(1'b0);
        repeat (5) @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got %b want 1", out_valid); end
        n_vec++; if (rom_addr !== 32'h8) begin n_err++; $display("FAIL bp_rom_addr got %h want 00000008", rom_addr); end
        n_vec++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL bp_head got %h want 0", out_pc); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) begin pcs.push_back(out_pc); flt.push_back(out_fault); end
            @(posedge clk);
            #1;
        end
        n_vec++; if (pcs.size() != 4) begin n_err++; $display("FAIL bp_count got %0d want 4", pcs.size()); end
        for (int i = 0; i < 4 && i < pcs.size(); i++) begin
            n_vec++; if (pcs[i] !== 32'(4 * i)) begin n_err++; $display("FAIL bp_order[%0d] got %h want %h", i, pcs[i], 32'(4 * i)); end
            n_vec++; if (flt[i] !== (i == 3)) begin n_err++; $display("FAIL bp_fault[%0d] got %b want %b", i, flt[i], (i == 3)); end
        end
        n_vec++; if (rom_addr !== 32'hC) begin n_err++; $display("FAIL bp_halt_pc got %h want 0000000c", rom_addr); end
    endtask

    task automatic test_redirect();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0040_0000;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        n_vec++; if (fetch_halted !== 1'b0) begin n_err++; $display("FAIL redir_halted got %b want 0", fetch_halted); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush got %b want 0", out_valid); end
        n_vec++; if (rom_addr !== 32'h0040_0000) begin n_err++; $display("FAIL redir_rom_addr got %h want 00400000", rom_addr); end
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h0040_0000) begin n_err++; $display("FAIL redir_first got v=%b pc=%h want v=1 pc=00400000", out_valid, out_pc); end
        n_vec++; if (out_inst !== rom_word(32'h0040_0000) || out_fault !== 1'b0) begin n_err++; $display("FAIL redir_first_inst got %h/%b want %h/0", out_inst, out_fault, rom_word(32'h0040_0000)); end
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h0040_0004) begin n_err++; $display("FAIL redir_second got v=%b pc=%h want v=1 pc=00400004", out_valid, out_pc); end
    endtask

    task automatic test_misaligned();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0040_0002;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mis_flush got %b want 0", out_valid); end
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h0040_0002) begin n_err++; $display("FAIL mis_entry got v=%b pc=%h want v=1 pc=00400002", out_valid, out_pc); end
        n_vec++; if (out_inst !== 32'h0 || out_fault !== 1'b1) begin n_err++; $display("FAIL mis_fault got %h/%b want 00000000/1", out_inst, out_fault); end
        n_vec++; if (fetch_halted !== 1'b1) begin n_err++; $display("FAIL mis_halted got %b want 1", fetch_halted); end
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mis_single got %b want 0", out_valid); end
    endtask

    task automatic test_redirect_full_pop();
        apply_reset(1'b0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0040_0010;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rfp_flush got %b want 0", out_valid); end
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h0040_0010) begin n_err++; $display("FAIL rfp_next got v=%b pc=%h want v=1 pc=00400010", out_valid, out_pc); end
    endtask

    task automatic test_reset_mid();
        apply_reset(1'b0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_async got %b want 0", out_valid); end
        n_vec++; if (rom_addr !== 32'h0) begin n_err++; $display("FAIL rmid_rom_addr got %h want 0", rom_addr); end
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h3c11_0040) begin n_err++; $display("FAIL rmid_restart got v=%b pc=%h inst=%h want v=1 pc=0 inst=3c110040", out_valid, out_pc, out_inst); end
    endtask

    task automatic test_random();
        logic        rdy, rdr, exp_v;
        logic [31:0] tgt;
        apply_reset(1'b1);
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rdr = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 4))
                0: tgt = 32'h0;
                1: tgt = 32'h0040_0000 + 32'(4 * $urandom_range(0, 60));
                2: tgt = 32'h0040_0000 + 32'($urandom_range(0, 255));
                3: tgt = 32'hFFFF_FFF0;
                default: tgt = 32'h0000_000C;
            endcase
            step(rdy, rdr, tgt);
            exp_v = (mq.size() != 0);
            n_vec++; if (rom_addr !== m_pc) begin n_err++; $display("FAIL rnd_rom_addr cyc %0d got %h want %h", i, rom_addr, m_pc); end
            n_vec++; if (fetch_halted !== m_halt) begin n_err++; $display("FAIL rnd_halted cyc %0d got %b want %b", i, fetch_halted, m_halt); end
            n_vec++; if (out_valid !== exp_v) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, out_valid, exp_v); end
            if (exp_v) begin
                n_vec++;
                if (out_pc !== mq[0].pc || out_inst !== mq[0].inst || out_fault !== mq[0].fault) begin
                    n_err++;
                    $display("FAIL rnd_head cyc %0d got %h/%h/%b want %h/%h/%b", i, out_pc, out_inst, out_fault, mq[0].pc, mq[0].inst, mq[0].fault);
                end
            end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_boot_sequence();
        test_redirect();
        test_misaligned();
        test_backpressure();
        test_redirect_full_pop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
